// File: rtl/loac_mem_pkg.sv
// Shared widths, access-sequence states and helpers for the register-memory port arbiter.
package loac_mem_pkg;

    localparam int ADDR_WIDTH = 2;
    localparam int DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef logic [ADDR_WIDTH-1:0] mem_addr_t;
    typedef logic [DATA_WIDTH-1:0] mem_data_t;

    // Index of the set bit in a two-requester one-hot vector.
    function automatic logic onehot2_idx(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins outright, contention goes to the
// requester that was not served last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single port of the small register memory between two requesters using a
// fixed IDLE -> ACCESS -> DONE sequence, one transaction in flight at a time.
module mem_port_arbiter
    import loac_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = loac_mem_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = loac_mem_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  txn_count
);

    arb_state_t            state;
    logic                  last;
    logic [1:0]            pick;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_arbiter2 u_rr (
        .req  (req),
        .last (last),
        .pick (pick)
    );

    // Port mux follows the registered grant, so everything reads zero while idle or in reset.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (gnt[0]) begin
            sel_we    = we[0];
            sel_addr  = addr0;
            sel_wdata = wdata0;
        end else if (gnt[1]) begin
            sel_we    = we[1];
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    assign mem_wr_en = (state == ACCESS) && sel_we;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            done      <= 2'b00;
            rdata     <= '0;
            txn_count <= '0;
            last      <= 1'b1;
        end else begin
            done <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= pick;
                        last  <= onehot2_idx(pick);
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A write echoes its own data; a read takes the contents before this edge.
                    rdata     <= sel_we ? sel_wdata : mem_rdata;
                    done      <= gnt;
                    txn_count <= txn_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state     <= DONE;
                end
                DONE: begin
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model tracks which requester
// is being served and how many cycles since its grant, and every cycle is compared.
module tb_mem_port_arbiter;

    logic       clk_2 = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] we = 2'b00;
    logic [1:0] addr0 = 2'd0, addr1 = 2'd0;
    logic [3:0] wdata0 = 4'd0, wdata1 = 4'd0;
    logic [3:0] mem_rdata;
    logic       mem_wr_en;
    logic [1:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [1:0] gnt, done;
    logic [3:0] rdata;
    logic       busy;
    logic [7:0] txn_count;

    int total = 0;
    int bad = 0;

    mem_port_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk_2 = ~clk_2;

    // The physical array the arbiter drives.
    logic [3:0] mem [4] = '{default: 4'd0};
    always @(posedge clk_2) if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    // Model: who is being served and cycles elapsed since the grant (0 = nobody).
    logic [3:0] mmem [4] = '{default: 4'd0};
    int         m_age = 0;
    logic       m_who = 1'b0;
    logic       m_last = 1'b1;
    logic [3:0] m_rdata = 4'd0;
    logic [7:0] m_cnt = 8'd0;

    always @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            m_age = 0; m_who = 1'b0; m_last = 1'b1; m_rdata = 4'd0; m_cnt = 8'd0;
        end else if (m_age == 0) begin
            if (req != 2'b00) begin
                m_who  = (req == 2'b11) ? ~m_last : req[1];
                m_last = m_who;
                m_age  = 1;
            end
        end else if (m_age == 1) begin
            if (we[m_who]) begin
                m_rdata = m_who ? wdata1 : wdata0;
                mmem[m_who ? addr1 : addr0] = m_rdata;
            end else begin
                m_rdata = mmem[m_who ? addr1 : addr0];
            end
            m_cnt++;
            m_age = 2;
        end else begin
            m_age = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        logic [1:0] eg, ed;
        eg = (m_age != 0) ? (2'b01 << m_who) : 2'b00;
        ed = (m_age == 2) ? (2'b01 << m_who) : 2'b00;
        chk("busy", 32'(busy), 32'(m_age != 0));
        chk("gnt", 32'(gnt), 32'(eg));
        chk("done", 32'(done), 32'(ed));
        chk("mem_wr_en", 32'(mem_wr_en), 32'((m_age == 1) && we[m_who]));
        chk("txn_count", 32'(txn_count), 32'(m_cnt));
        if (m_age == 1) begin
            chk("mem_addr", 32'(mem_addr), 32'(m_who ? addr1 : addr0));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_who ? wdata1 : wdata0));
        end
        if (m_age == 2) chk("rdata", 32'(rdata), 32'(m_rdata));
    endtask

    task automatic cyc();
        @(negedge clk_2);
        cmp_all();
    endtask

    task automatic set_req(input bit r, input bit w, input logic [1:0] a, input logic [3:0] d);
        if (r) begin
            req[1] = 1'b1; we[1] = w; addr1 = a; wdata1 = d;
        end else begin
            req[0] = 1'b1; we[0] = w; addr0 = a; wdata0 = d;
        end
    endtask

    // Latency counts the IDLE cycle in which the request is first seen as cycle 1.
    task automatic wait_done(input bit r, output int lat);
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            lat++;
            if (done[r]) return;
        end
        total++;
        bad++;
        $display("FAIL wait_done%0d: no done within budget", r);
    endtask

    task automatic do_txn(input bit r, input bit w, input logic [1:0] a, input logic [3:0] d,
                          input logic [3:0] exp_rd);
        int lat;
        set_req(r, w, a, d);
        wait_done(r, lat);
        chk("latency", 32'(lat), 32'd3);
        chk("txn_rdata", 32'(rdata), 32'(exp_rd));
        req[r] = 1'b0;
        cyc();
    endtask

    initial begin
        int n, idle_run, max_idle;
        bit order [3];

        // Reset state
        repeat (2) cyc();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cnt", 32'(txn_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        cyc();

        // Test 1: requester 0 writes 0xA to addr 2
        set_req(0, 1'b1, 2'd2, 4'hA);
        cyc();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_wr_en", 32'(mem_wr_en), 32'h1);
        chk("t1_addr", 32'(mem_addr), 32'h2);
        chk("t1_wdata", 32'(mem_wdata), 32'hA);
        cyc();
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_rdata", 32'(rdata), 32'hA);
        chk("t1_cnt", 32'(txn_count), 32'h1);
        req[0] = 1'b0;
        cyc();
        chk("t1_idle", 32'(busy), 32'h0);

        // Test 2: requester 1 reads addr 2 back
        do_txn(1, 1'b0, 2'd2, 4'h0, 4'hA);
        chk("t2_cnt", 32'(txn_count), 32'h2);

        // Test 3: simultaneous requests held through three grants
        set_req(0, 1'b1, 2'd1, 4'h3);
        set_req(1, 1'b0, 2'd1, 4'h0);
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            cyc();
            if (done != 2'b00) begin
                order[n] = done[1];
                n++;
            end
        end
        req = 2'b00;
        chk("t3_count", 32'(n), 32'd3);
        chk("t3_first", 32'(order[0]), 32'd0);
        chk("t3_second", 32'(order[1]), 32'd1);
        chk("t3_third", 32'(order[2]), 32'd0);
        cyc();

        // Test 4: requester 1 arrives while requester 0 is in ACCESS
        set_req(0, 1'b0, 2'd1, 4'h0);
        cyc();
        set_req(1, 1'b1, 2'd0, 4'h9);
        cyc();
        chk("t4_done0", 32'(done), 32'h1);
        chk("t4_rd0", 32'(rdata), 32'h3);
        req[0] = 1'b0;
        cyc();
        chk("t4_gap", 32'(busy), 32'h0);
        cyc();
        chk("t4_gnt1", 32'(gnt), 32'h2);
        cyc();
        chk("t4_done1", 32'(done), 32'h2);
        chk("t4_rd1", 32'(rdata), 32'h9);
        req[1] = 1'b0;
        cyc();

        // Test 5: reset lands in the ACCESS cycle of a write to addr 3
        do_txn(0, 1'b1, 2'd3, 4'h5, 4'h5);
        set_req(0, 1'b1, 2'd3, 4'hC);
        cyc();
        chk("t5_wr_en", 32'(mem_wr_en), 32'h1);
        reset = 1'b1;
        #1;
        cmp_all();
        chk("t5_gnt", 32'(gnt), 32'h0);
        chk("t5_wr_off", 32'(mem_wr_en), 32'h0);
        chk("t5_addr", 32'(mem_addr), 32'h0);
        chk("t5_wdata", 32'(mem_wdata), 32'h0);
        chk("t5_rdata", 32'(rdata), 32'h0);
        chk("t5_cnt", 32'(txn_count), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        req[0] = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        chk("t5_mem3", 32'(mem[3]), 32'h5);
        chk("t5_nodone", 32'(done), 32'h0);

        // Test 6: 256 back-to-back reads under continuous contention
        set_req(0, 1'b0, 2'd2, 4'h0);
        set_req(1, 1'b0, 2'd3, 4'h0);
        n = 0; idle_run = 0; max_idle = 0;
        for (int i = 0; i < 1000 && n < 256; i++) begin
            cyc();
            if (!busy) idle_run++;
            else idle_run = 0;
            if (idle_run > max_idle) max_idle = idle_run;
            if (done != 2'b00) begin
                n++;
                if (n == 255) chk("t6_cnt_ff", 32'(txn_count), 32'hFF);
                if (n == 256) chk("t6_cnt_wrap", 32'(txn_count), 32'h00);
            end
        end
        req = 2'b00;
        chk("t6_txns", 32'(n), 32'd256);
        chk("t6_max_idle", 32'(max_idle), 32'd1);
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
